pe_fp8_mac_v2: RTL and testbench

- Next-generation systolic processing element. It multiplies two FP8 operands and accumulates the product into a parametrised fixed-point accumulator.
- Each operand independently selects E4M3 or E5M2 format.
- The multiply/accumulate path is pipelined in two stages, with valid/clear sideband travelling alongside the data.
- Outputs: BF16 result, sticky overflow flag and sticky special-value flag. Tiles into an N×N array; A flows east, B flows south.

---
 rtl/pe_fp8_mac_v2_pkg.sv | 40 ++++
 rtl/pe_fp8_mac_v2_if.sv | 31 +++
 rtl/pe_fp8_mac_v2_acc_to_bf16.sv | 42 ++++
 rtl/pe_fp8_mac_v2.sv | 169 ++++++++++++++++
 tb/tb_pe_fp8_mac_v2.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_fp8_mac_v2_pkg.sv
// Shared types, constants and the FP8 operand decoder for the FP8 MAC processing element.
package pe_pkg;

   typedef enum logic {
      FMT_E4M3 = 1'b0,
      FMT_E5M2 = 1'b1
   } fp8_fmt_e;

   localparam int E4M3_BIAS       = 7;
   localparam int E5M2_BIAS       = 15;
   localparam int E4M3_DENORM_EXP = -6;
   localparam int E5M2_DENORM_EXP = -14;
   localparam int BF16_BIAS       = 127;

   typedef struct packed {
      logic              sign;
      logic [3:0]        mant;
      logic signed [5:0] exp;
      logic              special;
   } fp8_decode_t;

   // Both formats land on a 1.3 mantissa so the multiplier is shared.
   function automatic fp8_decode_t fp8_decode(fp8_fmt_e fmt, logic [7:0] x);
      fp8_decode_t d;
      int          e;
      d.sign = x[7];
      if (fmt == FMT_E4M3) begin
         d.mant    = {(x[6:3] != 4'd0), x[2:0]};
         e         = (x[6:3] == 4'd0) ? E4M3_DENORM_EXP : int'(x[6:3]) - E4M3_BIAS;
         d.special = (x[6:3] == 4'hF) && (x[2:0] == 3'h7);
      end else begin
         d.mant    = {(x[6:2] != 5'd0), x[1:0], 1'b0};
         e         = (x[6:2] == 5'd0) ? E5M2_DENORM_EXP : int'(x[6:2]) - E5M2_BIAS;
         d.special = (x[6:2] == 5'h1F);
      end
      d.exp = 6'(e);
      return d;
   endfunction

endpackage

// File: rtl/pe_fp8_mac_v2_if.sv
// Operand/result bundle of one processing element; slave is the PE side, master the driver side.
interface pe_fp8_mac_v2_if;
   logic        valid_in;
   logic        clear_in;
   logic        fmt_a;
   logic        fmt_b;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic [7:0]  a_out;
   logic [7:0]  b_out;
   logic        valid_out;
   logic        clear_out;
   logic        fmt_a_out;
   logic        fmt_b_out;
   logic        c_valid;
   logic [15:0] c_out;
   logic        ovf_flag;
   logic        special_flag;

   modport slave (
      input  valid_in, clear_in, fmt_a, fmt_b, a_in, b_in,
      output a_out, b_out, valid_out, clear_out, fmt_a_out, fmt_b_out,
             c_valid, c_out, ovf_flag, special_flag
   );

   modport master (
      output valid_in, clear_in, fmt_a, fmt_b, a_in, b_in,
      input  a_out, b_out, valid_out, clear_out, fmt_a_out, fmt_b_out,
             c_valid, c_out, ovf_flag, special_flag
   );
endinterface

// File: rtl/pe_fp8_mac_v2_acc_to_bf16.sv
// Combinational conversion of the signed fixed-point accumulator to BF16 (LZD + round-to-nearest-even).
module acc_to_bf16
   import pe_pkg::*;
#(
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 8
) (
   input  logic [ACC_W-1:0] acc,
   output logic [15:0]      bf16
);

   logic             sign;
   logic [ACC_W-1:0] mag;
   logic [ACC_W-1:0] norm;
   logic [6:0]       mant;
   logic [7:0]       mant_r;
   logic             guard;
   logic             sticky;
   logic             round_up;
   int unsigned      msb;
   int               exp_i;

   always_comb begin
      sign = acc[ACC_W-1];
      // The most negative value maps to 2^(ACC_W-1), which still fits unsigned.
      mag  = sign ? (~acc + 1'b1) : acc;
      msb  = 0;
      for (int unsigned i = 0; i < ACC_W; i++) begin
         if (mag[i]) msb = i;
      end
      norm     = mag << (ACC_W - 1 - msb);
      mant     = norm[ACC_W-2:ACC_W-8];
      guard    = norm[ACC_W-9];
      sticky   = |norm[ACC_W-10:0];
      round_up = guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {7'd0, round_up};
      exp_i    = BF16_BIAS + int'(msb) - FRAC_BITS + (mant_r[7] ? 1 : 0);
      if (mag == '0) bf16 = '0;
      else           bf16 = {sign, exp_i[7:0], mant_r[6:0]};
   end

endmodule

// File: rtl/pe_fp8_mac_v2.sv
// Systolic FP8 x FP8 multiply-accumulate PE with BF16 readout.
// Optional PE_SAT_ACC_EN: saturate the accumulator on signed add overflow instead of wrapping.
module pe_fp8_mac_v2
   import pe_pkg::*;
#(
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   pe_fp8_mac_v2_if.slave  pe
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [7:0] a_out_d, a_out_q, b_out_d, b_out_q;
   logic       valid_out_d, valid_out_q, clear_out_d, clear_out_q;
   logic       fmt_a_out_d, fmt_a_out_q, fmt_b_out_d, fmt_b_out_q;

   fp8_decode_t       dec_a, dec_b;
   logic              s1_sign_d, s1_sign_q;
   logic [7:0]        s1_mant_d, s1_mant_q;
   logic signed [6:0] s1_exp_d, s1_exp_q;
   logic              s1_special_d, s1_special_q;
   logic              s1_valid_d, s1_valid_q;
   logic              s1_clear_d, s1_clear_q;

   int               shr;
   logic [ACC_W+7:0] shl;
   logic [ACC_W-1:0] prod_mag;
   logic [ACC_W-1:0] prod_s;
   logic             prod_ovf;
   logic [ACC_W:0]   sum;
   logic             add_ovf;

   logic [ACC_W-1:0] acc_d, acc_q;
   logic             ovf_d, ovf_q, special_d, special_q;
   logic             c_valid_d, c_valid_q;
   logic [15:0]      c_out_w;

   always_comb begin
      a_out_d     = pe.a_in;
      b_out_d     = pe.b_in;
      valid_out_d = pe.valid_in;
      clear_out_d = pe.clear_in;
      fmt_a_out_d = pe.fmt_a;
      fmt_b_out_d = pe.fmt_b;
   end

   always_comb begin
      dec_a        = fp8_decode(fp8_fmt_e'(pe.fmt_a), pe.a_in);
      dec_b        = fp8_decode(fp8_fmt_e'(pe.fmt_b), pe.b_in);
      s1_sign_d    = dec_a.sign ^ dec_b.sign;
      s1_mant_d    = {4'd0, dec_a.mant} * {4'd0, dec_b.mant};
      s1_exp_d     = {dec_a.exp[5], dec_a.exp} + {dec_b.exp[5], dec_b.exp};
      s1_special_d = dec_a.special | dec_b.special;
      s1_valid_d   = pe.valid_in;
      s1_clear_d   = pe.clear_in;
   end

   // Align the 2.6 product onto the accumulator grid; large left shifts clamp the magnitude.
   always_comb begin
      shr      = 6 - FRAC_BITS - int'(s1_exp_q);
      shl      = '0;
      prod_mag = '0;
      prod_ovf = 1'b0;
      if (s1_special_q) begin
         prod_mag = '0;
      end else if (shr >= 8) begin
         prod_mag = '0;
      end else if (shr >= 0) begin
         prod_mag = ACC_W'(s1_mant_q >> shr);
      end else if (s1_mant_q != '0) begin
         if (-shr >= ACC_W - 1) begin
            prod_ovf = 1'b1;
         end else begin
            shl = {{ACC_W{1'b0}}, s1_mant_q} << (-shr);
            if (|shl[ACC_W+7:ACC_W-1]) prod_ovf = 1'b1;
            else                       prod_mag = shl[ACC_W-1:0];
         end
      end
      if (prod_ovf) prod_mag = ACC_MAX;
   end

   always_comb begin
      prod_s    = s1_sign_q ? -prod_mag : prod_mag;
      sum       = {acc_q[ACC_W-1], acc_q} + {prod_s[ACC_W-1], prod_s};
      add_ovf   = sum[ACC_W] ^ sum[ACC_W-1];
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      special_d = special_q;
      c_valid_d = s1_valid_q;
      if (s1_valid_q && s1_clear_q) begin
         acc_d     = prod_s;
         ovf_d     = prod_ovf;
         special_d = s1_special_q;
      end else if (s1_valid_q) begin
         acc_d     = sum[ACC_W-1:0];
         ovf_d     = ovf_q | prod_ovf | add_ovf;
         special_d = special_q | s1_special_q;
`ifdef PE_SAT_ACC_EN
         if (add_ovf) acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
      end else if (s1_clear_q) begin
         acc_d     = '0;
         ovf_d     = 1'b0;
         special_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out_q      <= '0;
         b_out_q      <= '0;
         valid_out_q  <= 1'b0;
         clear_out_q  <= 1'b0;
         fmt_a_out_q  <= 1'b0;
         fmt_b_out_q  <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_mant_q    <= '0;
         s1_exp_q     <= '0;
         s1_special_q <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_clear_q   <= 1'b0;
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         special_q    <= 1'b0;
         c_valid_q    <= 1'b0;
      end else begin
         a_out_q      <= a_out_d;
         b_out_q      <= b_out_d;
         valid_out_q  <= valid_out_d;
         clear_out_q  <= clear_out_d;
         fmt_a_out_q  <= fmt_a_out_d;
         fmt_b_out_q  <= fmt_b_out_d;
         s1_sign_q    <= s1_sign_d;
         s1_mant_q    <= s1_mant_d;
         s1_exp_q     <= s1_exp_d;
         s1_special_q <= s1_special_d;
         s1_valid_q   <= s1_valid_d;
         s1_clear_q   <= s1_clear_d;
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         special_q    <= special_d;
         c_valid_q    <= c_valid_d;
      end
   end

   acc_to_bf16 #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_acc_to_bf16 (
      .acc  (acc_q),
      .bf16 (c_out_w)
   );

   assign pe.a_out        = a_out_q;
   assign pe.b_out        = b_out_q;
   assign pe.valid_out    = valid_out_q;
   assign pe.clear_out    = clear_out_q;
   assign pe.fmt_a_out    = fmt_a_out_q;
   assign pe.fmt_b_out    = fmt_b_out_q;
   assign pe.c_valid      = c_valid_q;
   assign pe.c_out        = c_out_w;
   assign pe.ovf_flag     = ovf_q;
   assign pe.special_flag = special_q;

endmodule

// File: tb/tb_pe_fp8_mac_v2.sv
// Self-checking bench for pe_fp8_mac_v2: directed plan steps plus random traffic against a real-valued model.
module tb_pe_fp8_mac_v2;

   localparam int     ACC_W     = 24;
   localparam int     FRAC_BITS = 8;
   localparam longint ACC_MAX   = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint ACC_MIN   = -(longint'(1) <<< (ACC_W - 1));
   localparam longint ACC_MOD   = longint'(1) <<< ACC_W;

   typedef struct {
      bit         v;
      bit         c;
      bit         fa;
      bit         fb;
      logic [7:0] a;
      logic [7:0] b;
   } entry_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pe_fp8_mac_v2_if pe ();

   pe_fp8_mac_v2 #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pe    (pe)
   );

   int     checks   = 0;
   int     failures = 0;
   longint m_acc    = 0;
   bit     m_ovf    = 1'b0;
   bit     m_spec   = 1'b0;
   entry_t pend     = '{default: 0};
   entry_t idle     = '{default: 0};

   task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit fp8_special(bit f, logic [7:0] x);
      if (f) return x[6:2] == 5'h1F;
      return (x[6:3] == 4'hF) && (x[2:0] == 3'h7);
   endfunction

   function automatic real fp8_val(bit f, logic [7:0] x);
      real v;
      int  e;
      if (!f) begin
         e = int'(x[6:3]);
         v = (e == 0) ? (real'(x[2:0]) / 8.0) * (2.0 ** (-6))
                      : (1.0 + real'(x[2:0]) / 8.0) * (2.0 ** (e - 7));
      end else begin
         e = int'(x[6:2]);
         v = (e == 0) ? (real'(x[1:0]) / 4.0) * (2.0 ** (-14))
                      : (1.0 + real'(x[1:0]) / 4.0) * (2.0 ** (e - 15));
      end
      return x[7] ? -v : v;
   endfunction

   // BF16 by rounding the exact binary64 value of acc/2^FRAC_BITS.
   function automatic logic [15:0] to_bf16(longint acc);
      real         r;
      logic [63:0] bits;
      logic [15:0] top;
      logic [44:0] rem;
      logic [44:0] half;
      int          e;
      if (acc == 0) return 16'h0000;
      r    = real'(acc) / (2.0 ** FRAC_BITS);
      bits = $realtobits(r);
      e    = int'(bits[62:52]) - 1023 + 127;
      top  = {bits[63], e[7:0], bits[51:45]};
      rem  = bits[44:0];
      half = 45'h1000_0000_0000;
      if (rem > half || (rem == half && top[0])) top = top + 16'd1;
      return top;
   endfunction

   task automatic model_apply(entry_t en);
      bit     sp;
      bit     pov;
      real    p;
      real    mg;
      longint pr;
      longint s;
      if (!en.v) begin
         if (en.c) begin
            m_acc  = 0;
            m_ovf  = 1'b0;
            m_spec = 1'b0;
         end
         return;
      end
      sp  = fp8_special(en.fa, en.a) | fp8_special(en.fb, en.b);
      pov = 1'b0;
      pr  = 0;
      if (!sp) begin
         p  = fp8_val(en.fa, en.a) * fp8_val(en.fb, en.b) * (2.0 ** FRAC_BITS);
         mg = $floor((p < 0.0) ? -p : p);
         if (mg > real'(ACC_MAX)) begin
            mg  = real'(ACC_MAX);
            pov = 1'b1;
         end
         pr = longint'(mg);
         if (p < 0.0) pr = -pr;
      end
      if (en.c) begin
         m_acc  = pr;
         m_ovf  = pov;
         m_spec = sp;
      end else begin
         s      = m_acc + pr;
         m_ovf  = m_ovf | pov;
         m_spec = m_spec | sp;
         if (s > ACC_MAX || s < ACC_MIN) begin
            m_ovf = 1'b1;
`ifdef PE_SAT_ACC_EN
            s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
            s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
`endif
         end
         m_acc = s;
      end
   endtask

   task automatic step(bit v, bit c, bit fa, bit fb, logic [7:0] a, logic [7:0] b);
      entry_t cur;
      cur = '{v: v, c: c, fa: fa, fb: fb, a: a, b: b};
      pe.valid_in = v;
      pe.clear_in = c;
      pe.fmt_a    = fa;
      pe.fmt_b    = fb;
      pe.a_in     = a;
      pe.b_in     = b;
      @(posedge clk);
      #1;
      check("a_out", 16'(pe.a_out), 16'(a));
      check("b_out", 16'(pe.b_out), 16'(b));
      check("valid_out", 16'(pe.valid_out), 16'(v));
      check("clear_out", 16'(pe.clear_out), 16'(c));
      check("fmt_a_out", 16'(pe.fmt_a_out), 16'(fa));
      check("fmt_b_out", 16'(pe.fmt_b_out), 16'(fb));
      model_apply(pend);
      check("c_valid", 16'(pe.c_valid), 16'(pend.v));
      check("c_out", pe.c_out, to_bf16(m_acc));
      check("ovf_flag", 16'(pe.ovf_flag), 16'(m_ovf));
      check("special_flag", 16'(pe.special_flag), 16'(m_spec));
      pend = cur;
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_a_out"}, 16'(pe.a_out), 16'h0);
      check({tag, "_b_out"}, 16'(pe.b_out), 16'h0);
      check({tag, "_valid_out"}, 16'(pe.valid_out), 16'h0);
      check({tag, "_clear_out"}, 16'(pe.clear_out), 16'h0);
      check({tag, "_fmt_out"}, 16'({pe.fmt_a_out, pe.fmt_b_out}), 16'h0);
      check({tag, "_c_valid"}, 16'(pe.c_valid), 16'h0);
      check({tag, "_c_out"}, pe.c_out, 16'h0000);
      check({tag, "_flags"}, 16'({pe.ovf_flag, pe.special_flag}), 16'h0);
   endtask

   initial begin
      pe.valid_in = 1'b0;
      pe.clear_in = 1'b0;
      pe.fmt_a    = 1'b0;
      pe.fmt_b    = 1'b0;
      pe.a_in     = 8'h00;
      pe.b_in     = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      step(1, 1, 0, 0, 8'h38, 8'h38);
      check("first_c_valid_early", 16'(pe.c_valid), 16'h0);
      step(1, 0, 0, 0, 8'h40, 8'h38);
      check("one_x_one", pe.c_out, 16'h3F80);
      check("first_c_valid", 16'(pe.c_valid), 16'h1);
      step(1, 0, 0, 0, 8'hB8, 8'h40);
      check("three", pe.c_out, 16'h4040);
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("three_minus_two", pe.c_out, 16'h3F80);

      step(1, 1, 0, 1, 8'h38, 8'h3C);
      step(1, 0, 0, 0, 8'h01, 8'h38);
      check("mixed_fmt", pe.c_out, 16'h3F80);
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("underflow_hold", pe.c_out, 16'h3F80);

      step(1, 1, 0, 0, 8'h70, 8'h70);
      step(1, 0, 0, 0, 8'h70, 8'h70);
      step(1, 0, 0, 0, 8'h7F, 8'h38);
`ifdef PE_SAT_ACC_EN
      check("acc_ovf_c_out", pe.c_out, 16'h4700);
`else
      check("acc_ovf_c_out", pe.c_out, 16'hC700);
`endif
      check("acc_ovf_flag", 16'(pe.ovf_flag), 16'h1);
      step(1, 1, 0, 0, 8'h38, 8'h38);
      check("special_flag_set", 16'(pe.special_flag), 16'h1);
`ifdef PE_SAT_ACC_EN
      check("special_acc_hold", pe.c_out, 16'h4700);
`else
      check("special_acc_hold", pe.c_out, 16'hC700);
`endif
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("clear_after_special", pe.c_out, 16'h3F80);
      check("clear_flags", 16'({pe.ovf_flag, pe.special_flag}), 16'h0);
      step(0, 1, 0, 0, 8'h00, 8'h00);
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("bare_clear", pe.c_out, 16'h0000);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      step(1, 1, 0, 0, 8'h40, 8'h40);
      step(1, 0, 0, 0, 8'h40, 8'h38);
      pe.valid_in = 1'b0;
      pe.clear_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      m_acc  = 0;
      m_ovf  = 1'b0;
      m_spec = 1'b0;
      pend   = idle;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 8'h00, 8'h00);
         check("no_stale_c_valid", 16'(pe.c_valid), 16'h0);
         check("no_stale_c_out", pe.c_out, 16'h0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
